// File: rtl/message_buffer_pool.sv
// Multi-slot bus-burst collector: gathers bursts into N_SLOTS messages and presents them in order.
// Optional feature: define MSGBUF_OVERFLOW_CNT_EN to add the saturating overflow_cnt_o output.
module message_buffer_pool #(
  parameter int N_SLOTS        = 4,
  parameter int N_BITS_SLOT    = 2,
  parameter int MAX_BURST      = 8,
  parameter int N_BITS_BURST   = 3,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SEL_W          = 4,
  parameter int N_BITS_VNET_ID = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           ADR_I,
  input  logic [DATA_W-1:0]           DAT_I,
  input  logic [SEL_W-1:0]            SEL_I,
  input  logic                        WE_I,
  input  logic [N_BITS_VNET_ID-1:0]   vnet_id_i,
  input  logic                        is_valid_i,
  input  logic                        last_i,
  output logic                        ready_o,
  output logic [ADDR_W-1:0]           pkt_addr_o,
  output logic [MAX_BURST*DATA_W-1:0] pkt_data_o,
  output logic [MAX_BURST*SEL_W-1:0]  pkt_sel_o,
  output logic [N_BITS_BURST:0]       pkt_len_o,
  output logic                        pkt_we_o,
  output logic [N_BITS_VNET_ID-1:0]   vnet_id_o,
  output logic                        is_valid_o,
  input  logic                        ready_i,
  output logic [N_BITS_SLOT:0]        count_o
`ifdef MSGBUF_OVERFLOW_CNT_EN
  ,
  output logic [7:0]                  overflow_cnt_o
`endif
);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_FULL    = 2'd2
  } slot_state_e;

  localparam logic [N_BITS_SLOT-1:0]  PTR_ONE  = N_BITS_SLOT'(1);
  localparam logic [N_BITS_SLOT:0]    CNT_ONE  = (N_BITS_SLOT+1)'(1);
  localparam logic [N_BITS_BURST:0]   LEN_ONE  = (N_BITS_BURST+1)'(1);
  localparam logic [N_BITS_BURST-1:0] LAST_IDX = N_BITS_BURST'(MAX_BURST-1);

  slot_state_e               slot_state [N_SLOTS];
  logic [N_BITS_BURST:0]     slot_len   [N_SLOTS];
  logic [ADDR_W-1:0]         slot_addr  [N_SLOTS];
  logic                      slot_we    [N_SLOTS];
  logic [N_BITS_VNET_ID-1:0] slot_vnet  [N_SLOTS];
  logic [DATA_W-1:0]         slot_data  [N_SLOTS][MAX_BURST];
  logic [SEL_W-1:0]          slot_sel   [N_SLOTS][MAX_BURST];

  logic [N_BITS_SLOT-1:0]  wr_ptr, rd_ptr;
  logic [N_BITS_SLOT:0]    count_q;
  logic                    wr_free, accept, close, drain;
  logic [N_BITS_BURST-1:0] wr_idx;

  // While a slot is FILLING its length field doubles as the next chunk index.
  assign wr_free    = (slot_state[wr_ptr] == SLOT_FREE);
  assign wr_idx     = wr_free ? '0 : slot_len[wr_ptr][N_BITS_BURST-1:0];
  assign ready_o    = (slot_state[wr_ptr] != SLOT_FULL);
  assign accept     = is_valid_i & ready_o;
  assign close      = accept & (last_i | (wr_idx == LAST_IDX));
  assign is_valid_o = (slot_state[rd_ptr] == SLOT_FULL);
  assign drain      = is_valid_o & ready_i;
  assign count_o    = count_q;

  // NOTE: every output gets a default before the conditional mux so no latch is inferred.
  always_comb begin
    pkt_addr_o = '0;
    pkt_data_o = '0;
    pkt_sel_o  = '0;
    pkt_len_o  = '0;
    pkt_we_o   = 1'b0;
    vnet_id_o  = '0;
    if (is_valid_o) begin
      pkt_addr_o = slot_addr[rd_ptr];
      pkt_len_o  = slot_len[rd_ptr];
      pkt_we_o   = slot_we[rd_ptr];
      vnet_id_o  = slot_vnet[rd_ptr];
      for (int k = 0; k < MAX_BURST; k++) begin
        pkt_data_o[k*DATA_W +: DATA_W] = slot_data[rd_ptr][k];
        pkt_sel_o[k*SEL_W +: SEL_W]    = slot_sel[rd_ptr][k];
      end
    end
  end

  // NOTE: state is updated only with non-blocking assignments so all slot fields see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      // NOTE: payload arrays are reset explicitly because unused chunk words must read back as zero.
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_state[i] <= SLOT_FREE;
        slot_len[i]   <= '0;
        slot_addr[i]  <= '0;
        slot_we[i]    <= 1'b0;
        slot_vnet[i]  <= '0;
        for (int k = 0; k < MAX_BURST; k++) begin
          slot_data[i][k] <= '0;
          slot_sel[i][k]  <= '0;
        end
      end
    end else begin
      // A slot can never be both the accepting and the draining slot: one needs FULL, the other not.
      if (accept) begin
        if (wr_free) begin
          slot_addr[wr_ptr] <= ADR_I;
          slot_we[wr_ptr]   <= WE_I;
          slot_vnet[wr_ptr] <= vnet_id_i;
        end
        slot_data[wr_ptr][wr_idx] <= DAT_I;
        slot_sel[wr_ptr][wr_idx]  <= SEL_I;
        slot_len[wr_ptr]          <= {1'b0, wr_idx} + LEN_ONE;
        slot_state[wr_ptr]        <= close ? SLOT_FULL : SLOT_FILLING;
        if (close) wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (drain) begin
        slot_state[rd_ptr] <= SLOT_FREE;
        slot_len[rd_ptr]   <= '0;
        for (int k = 0; k < MAX_BURST; k++) begin
          slot_data[rd_ptr][k] <= '0;
          slot_sel[rd_ptr][k]  <= '0;
        end
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({close, drain})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef MSGBUF_OVERFLOW_CNT_EN
  logic [7:0] overflow_cnt_q;

  // A forced close is a close at the last index without the last marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_cnt_q <= '0;
    end else if (close && !last_i && overflow_cnt_q != 8'hFF) begin
      overflow_cnt_q <= overflow_cnt_q + 8'd1;
    end
  end

  assign overflow_cnt_o = overflow_cnt_q;
`endif

endmodule

// File: tb/tb_message_buffer_pool.sv
// Directed testbench for message_buffer_pool; exercises overflow_cnt_o when MSGBUF_OVERFLOW_CNT_EN is defined.
module tb_message_buffer_pool;

  localparam int MAX_BURST = 8;
  localparam int DATA_W    = 32;
  localparam int SEL_W     = 4;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [31:0]                 ADR_I = '0;
  logic [31:0]                 DAT_I = '0;
  logic [3:0]                  SEL_I = '0;
  logic                        WE_I = 1'b0;
  logic [1:0]                  vnet_id_i = '0;
  logic                        is_valid_i = 1'b0;
  logic                        last_i = 1'b0;
  logic                        ready_o;
  logic [31:0]                 pkt_addr_o;
  logic [MAX_BURST*DATA_W-1:0] pkt_data_o;
  logic [MAX_BURST*SEL_W-1:0]  pkt_sel_o;
  logic [3:0]                  pkt_len_o;
  logic                        pkt_we_o;
  logic [1:0]                  vnet_id_o;
  logic                        is_valid_o;
  logic                        ready_i = 1'b0;
  logic [2:0]                  count_o;
`ifdef MSGBUF_OVERFLOW_CNT_EN
  logic [7:0]                  overflow_cnt_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [MAX_BURST*DATA_W-1:0] exp_data;
  logic [MAX_BURST*SEL_W-1:0]  exp_sel;

  message_buffer_pool dut (
    .clk(clk), .rst(rst), .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I), .WE_I(WE_I),
    .vnet_id_i(vnet_id_i), .is_valid_i(is_valid_i), .last_i(last_i), .ready_o(ready_o),
    .pkt_addr_o(pkt_addr_o), .pkt_data_o(pkt_data_o), .pkt_sel_o(pkt_sel_o),
    .pkt_len_o(pkt_len_o), .pkt_we_o(pkt_we_o), .vnet_id_o(vnet_id_o),
    .is_valid_o(is_valid_o), .ready_i(ready_i), .count_o(count_o)
`ifdef MSGBUF_OVERFLOW_CNT_EN
    , .overflow_cnt_o(overflow_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input logic [1:0] vnet, input logic last);
    ADR_I = adr; DAT_I = dat; SEL_I = sel; WE_I = we; vnet_id_i = vnet; last_i = last;
    is_valid_i = 1'b1;
  endtask

  task automatic idle();
    is_valid_i = 1'b0;
    last_i     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); ready_i = 1'b0;
    step(); step();
    rst = 1'b0;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%0b exp=1", ready_o); end
    vectors++; if (is_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b exp=0", is_valid_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    vectors++; if (pkt_data_o !== '0 || pkt_sel_o !== '0 || pkt_len_o !== 4'd0 || pkt_addr_o !== 32'd0)
      begin miscompares++; $display("FAIL reset_pkt len=%0d addr=%h data=%h", pkt_len_o, pkt_addr_o, pkt_data_o); end
    vectors++; if (vnet_id_o !== 2'd0) begin miscompares++; $display("FAIL reset_vnet got=%0d exp=0", vnet_id_o); end
`ifdef MSGBUF_OVERFLOW_CNT_EN
    vectors++; if (overflow_cnt_o !== 8'd0) begin miscompares++; $display("FAIL reset_ovf got=%0d exp=0", overflow_cnt_o); end
`endif
  endtask

  task automatic test_single();
    ready_i = 1'b1;
    drive(32'h100, 32'hA5, 4'hF, 1'b1, 2'd2, 1'b1);
    step(); idle();
    exp_data = '0; exp_data[31:0] = 32'hA5;
    exp_sel  = '0; exp_sel[3:0]   = 4'hF;
    vectors++; if (is_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid got=%0b exp=1", is_valid_o); end
    vectors++; if (pkt_len_o !== 4'd1) begin miscompares++; $display("FAIL single_len got=%0d exp=1", pkt_len_o); end
    vectors++; if (pkt_data_o !== exp_data) begin miscompares++; $display("FAIL single_data got=%h exp=%h", pkt_data_o, exp_data); end
    vectors++; if (pkt_sel_o !== exp_sel) begin miscompares++; $display("FAIL single_sel got=%h exp=%h", pkt_sel_o, exp_sel); end
    vectors++; if (vnet_id_o !== 2'd2) begin miscompares++; $display("FAIL single_vnet got=%0d exp=2", vnet_id_o); end
    vectors++; if (pkt_addr_o !== 32'h100 || pkt_we_o !== 1'b1)
      begin miscompares++; $display("FAIL single_addr_we got=%h/%0b exp=100/1", pkt_addr_o, pkt_we_o); end
    vectors++; if (count_o !== 3'd1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", count_o); end
    step();
    vectors++; if (is_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_drained got=%0b exp=0", is_valid_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL single_count_after got=%0d exp=0", count_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_hold();
    ready_i = 1'b0;
    drive(32'h200, 32'h11, 4'h1, 1'b0, 2'd1, 1'b0); step();
    drive(32'hDEAD, 32'h22, 4'h3, 1'b1, 2'd3, 1'b0); step();
    drive(32'hBEEF, 32'h33, 4'hF, 1'b1, 2'd3, 1'b1); step();
    idle();
    exp_data = '0; exp_data[31:0] = 32'h11; exp_data[63:32] = 32'h22; exp_data[95:64] = 32'h33;
    exp_sel  = '0; exp_sel[3:0] = 4'h1; exp_sel[7:4] = 4'h3; exp_sel[11:8] = 4'hF;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (is_valid_o !== 1'b1 || pkt_len_o !== 4'd3 || count_o !== 3'd1)
        begin miscompares++; $display("FAIL hold_status cyc=%0d valid=%0b len=%0d count=%0d exp=1/3/1", c, is_valid_o, pkt_len_o, count_o); end
      vectors++; if (pkt_data_o !== exp_data || pkt_sel_o !== exp_sel)
        begin miscompares++; $display("FAIL hold_payload cyc=%0d data=%h sel=%h exp=%h/%h", c, pkt_data_o, pkt_sel_o, exp_data, exp_sel); end
      vectors++; if (pkt_addr_o !== 32'h200 || pkt_we_o !== 1'b0 || vnet_id_o !== 2'd1)
        begin miscompares++; $display("FAIL hold_header cyc=%0d addr=%h we=%0b vnet=%0d exp=200/0/1", c, pkt_addr_o, pkt_we_o, vnet_id_o); end
      step();
    end
    ready_i = 1'b1; step(); ready_i = 1'b0;
    vectors++; if (is_valid_o !== 1'b0 || count_o !== 3'd0)
      begin miscompares++; $display("FAIL hold_drain valid=%0b count=%0d exp=0/0", is_valid_o, count_o); end
  endtask

  task automatic test_pool_full();
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(32'h1000 + 32'(i), 32'(i), 4'h1, 1'b1, 2'd0, 1'b1); step();
    end
    idle();
    vectors++; if (ready_o !== 1'b0 || count_o !== 3'd4)
      begin miscompares++; $display("FAIL full_status ready=%0b count=%0d exp=0/4", ready_o, count_o); end
    drive(32'h1005, 32'd5, 4'h1, 1'b1, 2'd0, 1'b1); step();
    vectors++; if (ready_o !== 1'b0 || count_o !== 3'd4 || pkt_data_o[31:0] !== 32'd1)
      begin miscompares++; $display("FAIL full_held ready=%0b count=%0d head=%0d exp=0/4/1", ready_o, count_o, pkt_data_o[31:0]); end
    ready_i = 1'b1; step(); ready_i = 1'b0;
    vectors++; if (ready_o !== 1'b1 || count_o !== 3'd3 || pkt_data_o[31:0] !== 32'd2)
      begin miscompares++; $display("FAIL full_pulse ready=%0b count=%0d head=%0d exp=1/3/2", ready_o, count_o, pkt_data_o[31:0]); end
    step(); idle();
    vectors++; if (ready_o !== 1'b0 || count_o !== 3'd4)
      begin miscompares++; $display("FAIL full_fifth ready=%0b count=%0d exp=0/4", ready_o, count_o); end
    ready_i = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      vectors++; if (is_valid_o !== 1'b1 || pkt_data_o[31:0] !== 32'(i) || pkt_addr_o !== 32'h1000 + 32'(i))
        begin miscompares++; $display("FAIL full_order valid=%0b data=%0d addr=%h exp=1/%0d", is_valid_o, pkt_data_o[31:0], pkt_addr_o, i); end
      step();
    end
    ready_i = 1'b0;
    vectors++; if (is_valid_o !== 1'b0 || count_o !== 3'd0)
      begin miscompares++; $display("FAIL full_empty valid=%0b count=%0d exp=0/0", is_valid_o, count_o); end
  endtask

  task automatic test_overflow();
    ready_i = 1'b0;
    exp_data = '0; exp_sel = '0;
    for (int k = 0; k < 8; k++) begin
      drive((k == 0) ? 32'h300 : 32'hFFFF, 32'(k + 1), 4'(k + 1), 1'b1, 2'd3, 1'b0); step();
      exp_data[k*DATA_W +: DATA_W] = 32'(k + 1);
      exp_sel[k*SEL_W +: SEL_W]    = 4'(k + 1);
    end
    vectors++; if (is_valid_o !== 1'b1 || pkt_len_o !== 4'd8 || count_o !== 3'd1 || ready_o !== 1'b1)
      begin miscompares++; $display("FAIL ovf_close valid=%0b len=%0d count=%0d ready=%0b exp=1/8/1/1", is_valid_o, pkt_len_o, count_o, ready_o); end
    vectors++; if (pkt_data_o !== exp_data || pkt_sel_o !== exp_sel || pkt_addr_o !== 32'h300)
      begin miscompares++; $display("FAIL ovf_payload data=%h sel=%h addr=%h", pkt_data_o, pkt_sel_o, pkt_addr_o); end
    drive(32'h400, 32'd9, 4'h9, 1'b0, 2'd1, 1'b0); step();
    drive(32'h500, 32'hA, 4'hA, 1'b1, 2'd0, 1'b1); step();
    idle();
    vectors++; if (count_o !== 3'd2 || pkt_len_o !== 4'd8)
      begin miscompares++; $display("FAIL ovf_second count=%0d len=%0d exp=2/8", count_o, pkt_len_o); end
    ready_i = 1'b1; step();
    exp_data = '0; exp_data[31:0] = 32'd9; exp_data[63:32] = 32'hA;
    vectors++; if (is_valid_o !== 1'b1 || pkt_len_o !== 4'd2 || pkt_data_o !== exp_data)
      begin miscompares++; $display("FAIL ovf_next valid=%0b len=%0d data=%h exp=1/2/%h", is_valid_o, pkt_len_o, pkt_data_o, exp_data); end
    vectors++; if (pkt_addr_o !== 32'h400 || vnet_id_o !== 2'd1 || pkt_we_o !== 1'b0)
      begin miscompares++; $display("FAIL ovf_next_hdr addr=%h vnet=%0d we=%0b exp=400/1/0", pkt_addr_o, vnet_id_o, pkt_we_o); end
    step(); ready_i = 1'b0;
    vectors++; if (is_valid_o !== 1'b0 || count_o !== 3'd0)
      begin miscompares++; $display("FAIL ovf_empty valid=%0b count=%0d exp=0/0", is_valid_o, count_o); end
`ifdef MSGBUF_OVERFLOW_CNT_EN
    vectors++; if (overflow_cnt_o !== 8'd1) begin miscompares++; $display("FAIL ovf_count got=%0d exp=1", overflow_cnt_o); end
`endif
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0;
    drive(32'h600, 32'h55, 4'h1, 1'b0, 2'd0, 1'b1); step();
    drive(32'h700, 32'h66, 4'h3, 1'b0, 2'd0, 1'b0); step();
    drive(32'h700, 32'h67, 4'h3, 1'b0, 2'd0, 1'b0); step();
    idle();
    vectors++; if (count_o !== 3'd1) begin miscompares++; $display("FAIL rstmid_pre count=%0d exp=1", count_o); end
    rst = 1'b1; step(); rst = 1'b0;
    vectors++; if (is_valid_o !== 1'b0 || count_o !== 3'd0 || ready_o !== 1'b1)
      begin miscompares++; $display("FAIL rstmid_clear valid=%0b count=%0d ready=%0b exp=0/0/1", is_valid_o, count_o, ready_o); end
`ifdef MSGBUF_OVERFLOW_CNT_EN
    vectors++; if (overflow_cnt_o !== 8'd0) begin miscompares++; $display("FAIL rstmid_ovf got=%0d exp=0", overflow_cnt_o); end
`endif
    drive(32'h800, 32'h77, 4'h7, 1'b1, 2'd2, 1'b1); step(); idle();
    exp_data = '0; exp_data[31:0] = 32'h77;
    vectors++; if (is_valid_o !== 1'b1 || pkt_len_o !== 4'd1 || pkt_data_o !== exp_data || pkt_addr_o !== 32'h800)
      begin miscompares++; $display("FAIL rstmid_new valid=%0b len=%0d addr=%h data=%h", is_valid_o, pkt_len_o, pkt_addr_o, pkt_data_o); end
    ready_i = 1'b1; step(); ready_i = 1'b0;
    vectors++; if (is_valid_o !== 1'b0 || count_o !== 3'd0)
      begin miscompares++; $display("FAIL rstmid_drain valid=%0b count=%0d exp=0/0", is_valid_o, count_o); end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(32'(i * 16), 32'hB000 + 32'(i), 4'(i), 1'(i), 2'(i), 1'b1); step();
      exp_data = '0; exp_data[31:0] = 32'hB000 + 32'(i);
      vectors++; if (is_valid_o !== 1'b1 || pkt_data_o !== exp_data || pkt_len_o !== 4'd1)
        begin miscompares++; $display("FAIL b2b_data idx=%0d valid=%0b len=%0d word0=%h exp=%h", i, is_valid_o, pkt_len_o, pkt_data_o[31:0], exp_data[31:0]); end
      vectors++; if (pkt_addr_o !== 32'(i * 16) || vnet_id_o !== 2'(i) || pkt_sel_o[3:0] !== 4'(i))
        begin miscompares++; $display("FAIL b2b_hdr idx=%0d addr=%h vnet=%0d sel=%h", i, pkt_addr_o, vnet_id_o, pkt_sel_o[3:0]); end
      vectors++; if (count_o !== 3'd1 || ready_o !== 1'b1)
        begin miscompares++; $display("FAIL b2b_flow idx=%0d count=%0d ready=%0b exp=1/1", i, count_o, ready_o); end
    end
    idle(); step(); ready_i = 1'b0;
    vectors++; if (is_valid_o !== 1'b0 || count_o !== 3'd0)
      begin miscompares++; $display("FAIL b2b_end valid=%0b count=%0d exp=0/0", is_valid_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_pool_full();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
